matmul_apb_frontend: RTL and testbench

//  APB4 slave front end of the matmul accelerator. Terminates psel/penable/pwrite/pstrb/pwdata/paddr

---
 rtl/matmul_apb_frontend.sv | 214 +++++++++++++++++++++
 tb/tb_matmul_apb_frontend.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_apb_frontend.sv
`default_nettype none
// ============================================================================
// Module      : matmul_apb_frontend
// Description : APB4 slave front end of the matmul accelerator. Turns each APB
//               transfer into a single req/gnt/rvalid access to the operand,
//               result and control storage. Misaligned, out-of-range,
//               read-with-strobe and write-while-busy accesses are answered
//               locally with pslverr and never reach the storage.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_ni                 clock (rising edge), async reset (active low)
//   psel_i, penable_i, pwrite_i   APB control
//   pstrb_i [MAX_DIM]             per-element write strobe
//   pwdata_i, paddr_i             APB write data, byte address
//   pready_o, pslverr_o, prdata_o APB response
//   busy_i                        matmul core computing
//   mem_req_o .. mem_wdata_o      storage request side
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                   storage response side
// Configuration
//   MATMUL_APB_TIMEOUT_EN  defined: REQ/WAIT_RD abandon the access after
//                          TIMEOUT_CYC cycles and answer with pslverr.
// ============================================================================
module matmul_apb_frontend #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    BUS_WIDTH   = 32,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT  = 16'h1000,
    parameter int                    TIMEOUT_CYC = 64,
    localparam int                   MAX_DIM     = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [MAX_DIM-1:0]    pstrb_i,
    input  logic [BUS_WIDTH-1:0]  pwdata_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [BUS_WIDTH-1:0]  prdata_o,
    input  logic                  busy_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [MAX_DIM-1:0]    mem_be_o,
    output logic [BUS_WIDTH-1:0]  mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [BUS_WIDTH-1:0]  mem_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(BUS_WIDTH / 8 - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RD = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [BUS_WIDTH-1:0]  wdata_q;
    logic [BUS_WIDTH-1:0]  rdata_q;
    logic [MAX_DIM-1:0]    be_q;
    logic                  err_q;
    logic                  stale_q, stale_d;   // one granted read abandoned, its rvalid still due
    logic                  to_q;               // access abandoned by the watchdog
    logic                  timeout_hit;

    logic setup;
    logic err_dec;
    logic skip;
    logic rv_own;
    logic cap;

    assign setup   = (state_q == S_IDLE) & psel_i & ~penable_i;
    assign err_dec = (|(paddr_i & WORD_MASK))
                   | (paddr_i >= ADDR_LIMIT)
                   | (~pwrite_i & (|pstrb_i))
                   | (pwrite_i & busy_i);

    // Rejected transfers and strobe-less writes still pass through one REQ
    // cycle (with the request suppressed) so every answer has the same
    // two-cycle minimum latency.
    assign skip   = err_q | (we_q & ~(|be_q));
    assign rv_own = mem_rvalid_i & ~stale_q;

    assign mem_req_o   = (state_q == S_REQ) & psel_i & ~skip;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

    assign pready_o  = (state_q == S_RESP);
    assign pslverr_o = (state_q == S_RESP) & (err_q | to_q);
    assign prdata_o  = ((state_q == S_RESP) & ~we_q & ~err_q & ~to_q) ? rdata_q : '0;

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        stale_d = stale_q & ~mem_rvalid_i;   // the next rvalid retires a stale read
        case (state_q)
            S_IDLE: begin
                if (setup) state_d = S_REQ;
            end
            S_REQ: begin
                if (!psel_i) begin
                    state_d = S_IDLE;
                end else if (skip) begin
                    state_d = S_RESP;
                end else if (mem_gnt_i) begin
                    if (we_q) begin
                        state_d = S_RESP;
                    end else if (rv_own) begin
                        cap     = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT_RD;
                    end
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_WAIT_RD: begin
                if (!psel_i) begin
                    state_d = S_IDLE;
                    stale_d = ~rv_own;
                end else if (rv_own) begin
                    cap     = 1'b1;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    stale_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stale_q <= stale_d;
            if (setup) begin
                addr_q  <= paddr_i & ~WORD_MASK;
                we_q    <= pwrite_i;
                wdata_q <= pwdata_i;
                be_q    <= pstrb_i;
                err_q   <= err_dec;
                rdata_q <= '0;
            end else if (cap) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

`ifdef MATMUL_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_set;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    // Only a wait that is not being satisfied this very cycle counts as expired.
    assign to_set = timeout_hit & ((mem_req_o & ~mem_gnt_i)
                  | ((state_q == S_WAIT_RD) & psel_i & ~rv_own));

    // Counter restarts from zero on every state change.
    always_comb begin
        cnt_d = '0;
        if (((state_q == S_REQ) || (state_q == S_WAIT_RD)) && (state_d == state_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (setup)
                to_q <= 1'b0;
            else if (to_set)
                to_q <= 1'b1;
        end
    end
`else
    // Watchdog compiled out; the comparison keeps TIMEOUT_CYC referenced and
    // is constant false for any configurable value.
    assign timeout_hit = (TIMEOUT_CYC < 0);
    assign to_q        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_apb_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_apb_frontend
// Description : Directed self-checking bench for matmul_apb_frontend. Each
//               APB transfer pushes its expected response onto a scoreboard
//               queue; the entry is popped and compared when pready appears.
// Revision    : 1.0  initial release
// ============================================================================
module tb_matmul_apb_frontend;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        psel_i, penable_i, pwrite_i;
    logic [3:0]  pstrb_i;
    logic [31:0] pwdata_i;
    logic [15:0] paddr_i;
    logic        pready_o, pslverr_o;
    logic [31:0] prdata_o;
    logic        busy_i;
    logic        mem_req_o, mem_we_o;
    logic [15:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          reqs;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    matmul_apb_frontend #(
        .DATA_WIDTH (8),
        .BUS_WIDTH  (32),
        .ADDR_WIDTH (16),
        .ADDR_LIMIT (16'h1000),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .psel_i      (psel_i),
        .penable_i   (penable_i),
        .pwrite_i    (pwrite_i),
        .pstrb_i     (pstrb_i),
        .pwdata_i    (pwdata_i),
        .paddr_i     (paddr_i),
        .pready_o    (pready_o),
        .pslverr_o   (pslverr_o),
        .prdata_o    (prdata_o),
        .busy_i      (busy_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer with a cycle-by-cycle storage responder.
    // gnt_wait: request cycles refused before gnt. rv_wait: cycles from gnt to
    // rvalid (0 = same cycle). late_rv: inject a leftover rvalid with the gnt.
    task automatic xfer(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                        input logic late_rv, input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_reqs, input int exp_lat);
        exp_t        e, pe;
        int          req_seen, issued, rv_cnt, lat;
        logic        got;
        logic        o_err;
        logic [31:0] o_rd;
        logic [15:0] g_addr;
        logic [3:0]  g_be;
        logic        g_we;
        logic [31:0] g_wdata;
        e.err = exp_err; e.rdata = exp_rd; e.reqs = exp_reqs; e.lat = exp_lat;
        sb.push_back(e);
        req_seen = 0; issued = 0; rv_cnt = -1; lat = 0; got = 1'b0;
        o_err = 1'b0; o_rd = '0; g_addr = '0; g_be = '0; g_we = 1'b0; g_wdata = '0;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
        paddr_i = addr; pwdata_i = data; pstrb_i = strb;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            if (pready_o) begin
                got = 1'b1; lat = k + 1; o_err = pslverr_o; o_rd = prdata_o;
            end else begin
                mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
                if (mem_req_o) begin
                    if (req_seen == gnt_wait) begin
                        mem_gnt_i = 1'b1; issued++;
                        g_addr = mem_addr_o; g_be = mem_be_o; g_we = mem_we_o; g_wdata = mem_wdata_o;
                        if (!wr) rv_cnt = rv_wait;
                    end
                    req_seen++;
                end
                if (rv_cnt == 0) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = rdata; rv_cnt = -1;
                end else if (rv_cnt > 0) begin
                    rv_cnt--;
                end
                if (late_rv && k == 0) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
                end
                @(posedge clk_i); #1;
            end
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk({tag, " pready seen"}, {31'b0, got}, 32'd1);
        if (sb.size() > 0) begin
            pe = sb.pop_front();
            chk({tag, " pslverr"}, {31'b0, o_err}, {31'b0, pe.err});
            chk({tag, " prdata"}, o_rd, pe.rdata);
            chk({tag, " mem_req count"}, issued, pe.reqs);
            chk({tag, " latency"}, lat, pe.lat);
        end else begin
            chk({tag, " scoreboard entries"}, sb.size(), 32'd1);
        end
        if (issued > 0) begin
            chk({tag, " mem_addr"}, {16'b0, g_addr}, {16'b0, addr});
            chk({tag, " mem_be"}, {28'b0, g_be}, {28'b0, strb});
            chk({tag, " mem_we"}, {31'b0, g_we}, {31'b0, wr});
            if (wr) chk({tag, " mem_wdata"}, g_wdata, data);
        end
        psel_i = 1'b0; penable_i = 1'b0;
        @(posedge clk_i); #1;
        chk({tag, " pready after resp"}, {31'b0, pready_o}, 32'd0);
        chk({tag, " prdata after resp"}, prdata_o, 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        pstrb_i = '0; pwdata_i = '0; paddr_i = '0; busy_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset pready", {31'b0, pready_o}, 32'd0);
        chk("reset pslverr", {31'b0, pslverr_o}, 32'd0);
        chk("reset prdata", prdata_o, 32'd0);
        chk("reset mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("reset mem_we", {31'b0, mem_we_o}, 32'd0);
        chk("reset mem_addr", {16'b0, mem_addr_o}, 32'd0);
        chk("reset mem_be", {28'b0, mem_be_o}, 32'd0);
        chk("reset mem_wdata", mem_wdata_o, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        //   tag            wr    addr      data           strb  gw   rw  rdata         late  err   exp_rd        reqs lat
        xfer("wr 0x010",   1'b1, 16'h0010, 32'h0403_0201, 4'hF, 0,   0, 32'h0,        1'b0, 1'b0, 32'h0,        1,   2);
        xfer("rd 0x010",   1'b0, 16'h0010, 32'h0,         4'h0, 3,   1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1,  6);
        xfer("rd misalign",1'b0, 16'h0012, 32'h0,         4'h0, 0,   1, 32'h5555_5555, 1'b0, 1'b1, 32'h0,        0,   2);
        xfer("wr limit",   1'b1, 16'h1000, 32'h1111_2222, 4'hF, 0,   0, 32'h0,        1'b0, 1'b1, 32'h0,        0,   2);
        xfer("rd strobe",  1'b0, 16'h0010, 32'h0,         4'h1, 0,   1, 32'h6666_6666, 1'b0, 1'b1, 32'h0,        0,   2);
        busy_i = 1'b1;
        xfer("wr busy",    1'b1, 16'h0020, 32'hA5A5_A5A5, 4'hF, 0,   0, 32'h0,        1'b0, 1'b1, 32'h0,        0,   2);
        busy_i = 1'b0;
        xfer("wr idle",    1'b1, 16'h0020, 32'hA5A5_A5A5, 4'hF, 0,   0, 32'h0,        1'b0, 1'b0, 32'h0,        1,   2);
        xfer("wr nostrb",  1'b1, 16'h0050, 32'h7777_8888, 4'h0, 0,   0, 32'h0,        1'b0, 1'b0, 32'h0,        0,   2);
        xfer("wr top",     1'b1, 16'h0FFC, 32'h99AA_BBCC, 4'h5, 2,   0, 32'h0,        1'b0, 1'b0, 32'h0,        1,   4);
        xfer("rd gnt+rv",  1'b0, 16'h0100, 32'h0,         4'h0, 1,   0, 32'h1357_9BDF, 1'b0, 1'b0, 32'h1357_9BDF, 1,  3);

        // Abort a read after its gnt, before its rvalid.
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 16'h0030; pstrb_i = 4'h0;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        chk("abort mem_req", {31'b0, mem_req_o}, 32'd1);
        mem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0;
        chk("abort req dropped", {31'b0, mem_req_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("abort no pready", {31'b0, pready_o}, 32'd0);
        end
        // The aborted read's rvalid shows up alongside the next read's gnt.
        xfer("rd after abort", 1'b0, 16'h0030, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 1, 3);

`ifdef MATMUL_APB_TIMEOUT_EN
        xfer("wr no gnt",  1'b1, 16'h0040, 32'h0BAD_0BAD, 4'hF, 100, 0, 32'h0,        1'b0, 1'b1, 32'h0,        0,   9);
`else
        xfer("wr no gnt",  1'b1, 16'h0040, 32'h0BAD_0BAD, 4'hF, 100, 0, 32'h0,        1'b0, 1'b0, 32'h0,        1, 102);
`endif

        // Reset asserted while a write is requesting.
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 16'h0060;
        pwdata_i = 32'hFACE_0001; pstrb_i = 4'hF;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        chk("midrst mem_req before", {31'b0, mem_req_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("midrst mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("midrst mem_addr", {16'b0, mem_addr_o}, 32'd0);
        chk("midrst mem_wdata", mem_wdata_o, 32'd0);
        psel_i = 1'b0; penable_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("midrst pready", {31'b0, pready_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
